// File: rtl/decoder_align_pkg.sv
// Shared types for the fetch-to-issue aligner/decoder: the decoded instruction
// record, one halfword buffer entry, the aligner FSM states and encoding-length helpers.
package decoder_align_pkg;

    localparam int INSTR_BITS = 32;
    localparam int PC_BITS    = 32;

    typedef enum logic [1:0] {
        CF_NONE,
        CF_BRANCH,
        CF_JAL,
        CF_JALR
    } cf_kind_e;

    typedef struct packed {
        logic [PC_BITS-1:0]    pc;
        logic [INSTR_BITS-1:0] raw;            // compressed forms are zero-extended
        logic                  is_compressed;
        logic [4:0]            rd;
        logic [4:0]            rs1;
        logic [4:0]            rs2;
        logic [31:0]           imm;
        cf_kind_e              cf;
    } decoded_instr;

    typedef struct packed {
        logic [15:0]        data;
        logic [PC_BITS-1:0] pc;
        logic               taken_tag;         // predicted-taken instruction ends here
    } hw_entry_t;

    typedef enum logic {
        RUN,
        HOLD
    } align_state_e;

    // Low bits other than 11 mark a 16-bit instruction.
    function automatic logic hw_is_16(input logic [15:0] d);
        return d[1:0] != 2'b11;
    endfunction

    // 11 in the low bits with 111 above selects an unsupported (>32-bit) length.
    function automatic logic hw_is_illegal(input logic [15:0] d);
        return (d[1:0] == 2'b11) && (d[4:2] == 3'b111);
    endfunction

endpackage

// File: rtl/decoder_align_slot.sv
// One decode lane: the full 32-bit decoder, the compressed decoder and the
// lane wrapper (decoder_slot) that picks between them by instruction length.
module decoder_full
    import decoder_align_pkg::*;
(
    input  logic [INSTR_BITS-1:0] raw,
    input  logic [PC_BITS-1:0]    pc,
    output decoded_instr          dec,
    output logic                  is_return,
    output logic                  is_jumpl
);
    // Field extraction and control-flow classification of a 32-bit encoding.
    always_comb begin
        dec               = '0;
        dec.pc            = pc;
        dec.raw           = raw;
        dec.is_compressed = 1'b0;
        dec.rd            = raw[11:7];
        dec.rs1           = raw[19:15];
        dec.rs2           = raw[24:20];
        dec.imm           = {{20{raw[31]}}, raw[31:20]};
        dec.cf            = CF_NONE;
        is_return         = 1'b0;
        is_jumpl          = 1'b0;
        case (raw[6:0])
            7'b1100011: begin
                dec.cf  = CF_BRANCH;
                dec.imm = {{19{raw[31]}}, raw[31], raw[7], raw[30:25], raw[11:8], 1'b0};
            end
            7'b1101111: begin
                dec.cf  = CF_JAL;
                dec.imm = {{11{raw[31]}}, raw[31], raw[19:12], raw[20], raw[30:21], 1'b0};
            end
            7'b1100111: begin
                dec.cf    = CF_JALR;
                // jalr x0, 0(ra) is a return; every other jalr is an indirect jump
                is_return = (raw[11:7] == 5'd0) && (raw[19:15] == 5'd1);
                is_jumpl  = !is_return;
            end
            default: ;
        endcase
    end
endmodule

module decoder_compressed
    import decoder_align_pkg::*;
(
    input  logic [15:0]        hw,
    input  logic [PC_BITS-1:0] pc,
    output decoded_instr       dec,
    output logic               is_return,
    output logic               is_jumpl
);
    // Field extraction and control-flow classification of a 16-bit encoding.
    always_comb begin
        dec               = '0;
        dec.pc            = pc;
        dec.raw           = {16'h0000, hw};
        dec.is_compressed = 1'b1;
        dec.rd            = hw[11:7];
        dec.rs1           = hw[11:7];
        dec.rs2           = hw[6:2];
        dec.imm           = {{26{hw[12]}}, hw[12], hw[6:2]};
        dec.cf            = CF_NONE;
        is_return         = 1'b0;
        is_jumpl          = 1'b0;
        case ({hw[1:0], hw[15:13]})
            5'b01_001, 5'b01_101: begin        // C.JAL / C.J
                dec.cf  = CF_JAL;
                dec.rd  = {4'b0000, !hw[15]};
                dec.rs1 = 5'd0;
                dec.rs2 = 5'd0;
                dec.imm = {{20{hw[12]}}, hw[12], hw[8], hw[10:9], hw[6], hw[7],
                           hw[2], hw[11], hw[5:3], 1'b0};
            end
            5'b01_110, 5'b01_111: begin        // C.BEQZ / C.BNEZ
                dec.cf  = CF_BRANCH;
                dec.rs1 = {2'b01, hw[9:7]};
                dec.rs2 = 5'd0;
                dec.imm = {{23{hw[12]}}, hw[12], hw[6:5], hw[2], hw[11:10], hw[4:3], 1'b0};
            end
            5'b10_100: begin                   // C.JR / C.JALR when rs2 is zero
                if (hw[6:2] == 5'd0 && hw[11:7] != 5'd0) begin
                    dec.cf    = CF_JALR;
                    dec.rd    = {4'b0000, hw[12]};
                    dec.rs2   = 5'd0;
                    dec.imm   = '0;
                    is_return = !hw[12] && (hw[11:7] == 5'd1);
                    is_jumpl  = !is_return;
                end
            end
            default: ;
        endcase
    end
endmodule

module decoder_slot
    import decoder_align_pkg::*;
(
    input  logic [INSTR_BITS-1:0] raw,
    input  logic [PC_BITS-1:0]    pc,
    input  logic                  is_compressed,
    output decoded_instr          dec,
    output logic                  valid_branch,
    output logic                  is_return,
    output logic                  is_jumpl
);
    decoded_instr dec_full, dec_comp;
    logic         ret_full, ret_comp, jl_full, jl_comp;

    decoder_full u_full (
        .raw       (raw),
        .pc        (pc),
        .dec       (dec_full),
        .is_return (ret_full),
        .is_jumpl  (jl_full)
    );

    decoder_compressed u_comp (
        .hw        (raw[15:0]),
        .pc        (pc),
        .dec       (dec_comp),
        .is_return (ret_comp),
        .is_jumpl  (jl_comp)
    );

    // Select the decoder matching the instruction length.
    always_comb begin
        dec          = is_compressed ? dec_comp : dec_full;
        is_return    = is_compressed ? ret_comp : ret_full;
        is_jumpl     = is_compressed ? jl_comp  : jl_full;
        valid_branch = (dec.cf != CF_NONE);
    end
endmodule

// File: rtl/decoder_align.sv
// Fetch-packet aligner and multi-issue decoder. Halfwords land in a circular
// buffer; up to DEC_WIDTH mixed 16/32-bit instructions are extracted per cycle.
// Optional statistics counters are enabled by DECODER_ALIGN_STATS_EN.
//
// Handshakes: a fetch packet transfers on a cycle where valid_i & ready_o;
// slots are pushed to the queue on cycles where ready_i is high (ready_i means
// DEC_WIDTH free slots, so valid_o never waits on ready_i within the cycle).
module decoder_align
    import decoder_align_pkg::*;
#(
    parameter int FETCH_HW  = 4,
    parameter int DEC_WIDTH = 2,
    parameter int BUF_HW    = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_i,
    output logic                         ready_o,
    input  logic [PC_BITS-1:0]           pc_in,
    input  logic [16*FETCH_HW-1:0]       fetch_in,
    input  logic                         taken_branch,
    input  logic [$clog2(FETCH_HW)-1:0]  taken_idx,
    input  logic                         flush_i,
    input  logic                         ready_i,
    output logic [DEC_WIDTH-1:0]         valid_o,
    output decoded_instr [DEC_WIDTH-1:0] instr_o,
    output logic [DEC_WIDTH-1:0]         valid_branch,
    output logic                         invalid_instruction,
    output logic                         invalid_prediction,
    output logic                         is_return_out,
    output logic                         is_jumpl_out,
`ifdef DECODER_ALIGN_STATS_EN
    output logic [31:0]                  stat_stall_cycles,
    output logic [31:0]                  stat_split_instr,
    output logic [31:0]                  stat_dual_issue,
`endif
    output logic [PC_BITS-1:0]           old_pc
);
    localparam int PW = $clog2(BUF_HW);
    localparam int CW = PW + 1;
    localparam int IW = $clog2(FETCH_HW);

    typedef logic [CW:0] off_t;

    hw_entry_t          hw_buf [BUF_HW];
    logic [PW-1:0]      head, tail;
    logic [CW-1:0]      count;
    off_t               count_x, pop, push_n;
    align_state_e       state, state_n;
    logic [PC_BITS-1:0] old_pc_q, redir_pc;

    logic [INSTR_BITS-1:0] slot_raw [DEC_WIDTH];
    logic [PC_BITS-1:0]    slot_pc  [DEC_WIDTH];
    logic [DEC_WIDTH-1:0]  slot_c, slot_bad, slot_avail, slot_full, slot_tag, slot_tag_lo;
    logic [DEC_WIDTH-1:0]  dec_vb, dec_ret, dec_jl;
    logic                  inv_instr, inv_pred, redirect, enq;

`ifdef DECODER_ALIGN_STATS_EN
    logic                 pkt_start [BUF_HW];
    logic [DEC_WIDTH-1:0] slot_split;
    logic [7:0]           n_split;
    logic [32:0]          split_sum;
`endif

    assign count_x = {1'b0, count};

    // Walk the buffer from head: each slot starts where the previous one ends.
    always_comb begin
        off_t          off;
        logic [PW-1:0] i0, i1;
        off = '0;
        for (int k = 0; k < DEC_WIDTH; k++) begin
            i0             = head + off[PW-1:0];
            i1             = i0 + PW'(1);
            slot_raw[k]    = {hw_buf[i1].data, hw_buf[i0].data};
            slot_pc[k]     = hw_buf[i0].pc;
            slot_c[k]      = hw_is_16(hw_buf[i0].data);
            slot_bad[k]    = hw_is_illegal(hw_buf[i0].data);
            slot_avail[k]  = off < count_x;
            slot_full[k]   = slot_avail[k] && (slot_c[k] || ((off + off_t'(1)) < count_x));
            slot_tag_lo[k] = hw_buf[i0].taken_tag;
            slot_tag[k]    = hw_buf[i0].taken_tag || (!slot_c[k] && hw_buf[i1].taken_tag);
`ifdef DECODER_ALIGN_STATS_EN
            slot_split[k]  = !slot_c[k] && pkt_start[i1];
`endif
            off            = off + (slot_c[k] ? off_t'(1) : off_t'(2));
        end
    end

    for (genvar k = 0; k < DEC_WIDTH; k++) begin : g_slot
        decoder_slot u_slot (
            .raw           (slot_raw[k]),
            .pc            (slot_pc[k]),
            .is_compressed (slot_c[k]),
            .dec           (instr_o[k]),
            .valid_branch  (dec_vb[k]),
            .is_return     (dec_ret[k]),
            .is_jumpl      (dec_jl[k])
        );
    end

    // Emit contiguous slots until one is missing, illegal, mispredicted or ends a fetch block.
    always_comb begin
        logic stop;
        stop          = !ready_i || (state != RUN);
        valid_o       = '0;
        valid_branch  = '0;
        inv_instr     = 1'b0;
        inv_pred      = 1'b0;
        redir_pc      = old_pc_q;
        pop           = '0;
        is_return_out = 1'b0;
        is_jumpl_out  = 1'b0;
`ifdef DECODER_ALIGN_STATS_EN
        n_split       = '0;
`endif
        for (int k = 0; k < DEC_WIDTH; k++) begin
            if (!stop) begin
                if (!slot_avail[k]) begin
                    stop = 1'b1;
                end else if (slot_bad[k]) begin
                    inv_instr = 1'b1;
                    redir_pc  = slot_pc[k];
                    stop      = 1'b1;
                end else if (!slot_c[k] && slot_tag_lo[k]) begin
                    // prediction claims an instruction ends inside a 32-bit encoding
                    inv_pred = 1'b1;
                    redir_pc = slot_pc[k];
                    stop     = 1'b1;
                end else if (!slot_full[k]) begin
                    stop = 1'b1;                       // upper half still in flight
                end else if (slot_tag[k] && !dec_vb[k]) begin
                    inv_pred = 1'b1;
                    redir_pc = slot_pc[k];
                    stop     = 1'b1;
                end else begin
                    valid_o[k]      = 1'b1;
                    valid_branch[k] = dec_vb[k];
                    pop             = pop + (slot_c[k] ? off_t'(1) : off_t'(2));
                    is_return_out   = is_return_out | dec_ret[k];
                    is_jumpl_out    = is_jumpl_out | dec_jl[k];
`ifdef DECODER_ALIGN_STATS_EN
                    n_split         = n_split + {7'd0, slot_split[k]};
`endif
                    if (slot_tag[k] || dec_ret[k] || dec_jl[k]) stop = 1'b1;
                end
            end
        end
    end

    assign redirect            = inv_instr | inv_pred;
    assign invalid_instruction = inv_instr & !flush_i;
    assign invalid_prediction  = inv_pred & !flush_i;
    assign old_pc              = (redirect && !flush_i) ? redir_pc : old_pc_q;

    // Packet acceptance: space is judged after this cycle's pops; HOLD always accepts (and drops).
    always_comb begin
        push_n = taken_branch ? (off_t'(taken_idx) + off_t'(1)) : off_t'(FETCH_HW);
        if (state == HOLD) ready_o = 1'b1;
        else               ready_o = (count_x - pop + off_t'(FETCH_HW)) <= off_t'(BUF_HW);
        enq = valid_i && ready_o && !flush_i && !redirect &&
              ((state == RUN) || (pc_in == old_pc_q));
    end

    // Next-state: flush wins, then redirect, then the restart packet in HOLD.
    always_comb begin
        state_n = state;
        if (flush_i)                        state_n = RUN;
        else if (state == RUN && redirect)  state_n = HOLD;
        else if (state == HOLD && enq)      state_n = RUN;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= RUN;
        else     state <= state_n;
    end

    // Buffer pointers, occupancy and the latched restart PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            old_pc_q <= '0;
        end else begin
            if (flush_i || redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                head  <= head + pop[PW-1:0];
                tail  <= tail + (enq ? push_n[PW-1:0] : '0);
                count <= count - pop[CW-1:0] + (enq ? push_n[CW-1:0] : '0);
            end
            if (redirect && !flush_i) old_pc_q <= redir_pc;
        end
    end

    // Halfword storage; validity is tracked by count, so contents need no reset.
    always_ff @(posedge clk) begin
        if (enq) begin
            for (int i = 0; i < FETCH_HW; i++) begin
                if (off_t'(i) < push_n) begin
                    hw_buf[tail + PW'(i)].data      <= fetch_in[16*i +: 16];
                    hw_buf[tail + PW'(i)].pc        <= pc_in + PC_BITS'(2 * i);
                    hw_buf[tail + PW'(i)].taken_tag <= taken_branch && (IW'(i) == taken_idx);
`ifdef DECODER_ALIGN_STATS_EN
                    pkt_start[tail + PW'(i)]        <= (i == 0);
`endif
                end
            end
        end
    end

`ifdef DECODER_ALIGN_STATS_EN
    assign split_sum = {1'b0, stat_split_instr} + {25'd0, n_split};

    // Saturating performance counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_stall_cycles <= '0;
            stat_split_instr  <= '0;
            stat_dual_issue   <= '0;
        end else begin
            if (!ready_i && (count != '0) && (stat_stall_cycles != '1))
                stat_stall_cycles <= stat_stall_cycles + 32'd1;
            stat_split_instr <= split_sum[32] ? '1 : split_sum[31:0];
            if (($countones(valid_o) >= 2) && (stat_dual_issue != '1))
                stat_dual_issue <= stat_dual_issue + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decoder_align.sv
// Directed bench for decoder_align: alignment, split instructions, control-flow
// termination, prediction checks, illegal encodings, flush, backpressure, reset.
`define CHK(tag, obs, exp) check(tag, 64'(obs), 64'(exp))

module tb_decoder_align;
  import decoder_align_pkg::*;

  logic               clk = 1'b0;
  logic               rst;
  logic               valid_i;
  logic               ready_o;
  logic [31:0]        pc_in;
  logic [63:0]        fetch_in;
  logic               taken_branch;
  logic [1:0]         taken_idx;
  logic               flush_i;
  logic               ready_i;
  logic [1:0]         valid_o;
  decoded_instr [1:0] instr_o;
  logic [1:0]         valid_branch;
  logic               invalid_instruction;
  logic               invalid_prediction;
  logic               is_return_out;
  logic               is_jumpl_out;
  logic [31:0]        old_pc;

  int checks = 0;
  int errors = 0;

  decoder_align dut (
    .clk                 (clk),
    .rst                 (rst),
    .valid_i             (valid_i),
    .ready_o             (ready_o),
    .pc_in               (pc_in),
    .fetch_in            (fetch_in),
    .taken_branch        (taken_branch),
    .taken_idx           (taken_idx),
    .flush_i             (flush_i),
    .ready_i             (ready_i),
    .valid_o             (valid_o),
    .instr_o             (instr_o),
    .valid_branch        (valid_branch),
    .invalid_instruction (invalid_instruction),
    .invalid_prediction  (invalid_prediction),
    .is_return_out       (is_return_out),
    .is_jumpl_out        (is_jumpl_out),
    .old_pc              (old_pc)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired before the directed sequence completed");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    checks++;
    if (!ready_i && (valid_o !== 2'b00)) begin
      errors++;
      $error("FAIL mon_backpressure valid_o=%0b with ready_i=0", valid_o);
    end
    checks++;
    if ((valid_branch & ~valid_o) !== 2'b00) begin
      errors++;
      $error("FAIL mon_branch_subset valid_branch=%0b valid_o=%0b", valid_branch, valid_o);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] pc, input logic [15:0] h0, input logic [15:0] h1,
                       input logic [15:0] h2, input logic [15:0] h3,
                       input logic tb, input logic [1:0] tidx);
    valid_i      = 1'b1;
    pc_in        = pc;
    fetch_in     = {h3, h2, h1, h0};
    taken_branch = tb;
    taken_idx    = tidx;
  endtask

  task automatic idle();
    valid_i      = 1'b0;
    taken_branch = 1'b0;
    taken_idx    = 2'd0;
  endtask

  initial begin
    rst = 1'b1; flush_i = 1'b0; ready_i = 1'b0;
    pc_in = '0; fetch_in = '0;
    idle();
    repeat (2) @(posedge clk);
    #1;
    `CHK("rst_ready_o", ready_o, 1'b1);
    `CHK("rst_valid_o", valid_o, 2'b00);
    `CHK("rst_valid_branch", valid_branch, 2'b00);
    `CHK("rst_redirects", {invalid_instruction, invalid_prediction, is_return_out, is_jumpl_out}, 4'b0000);
    `CHK("rst_old_pc", old_pc, 32'h0);
    rst = 1'b0;

    drive(32'h100, 16'h0001, 16'h0001, 16'h0001, 16'h0093, 1'b0, 2'd0);
    #1 `CHK("pre_rst_ready_o", ready_o, 1'b1);
    tick(); idle();
    #1 `CHK("pre_rst_bp_valid_o", valid_o, 2'b00);
    rst = 1'b1; #1; rst = 1'b0; ready_i = 1'b1;
    #1 `CHK("async_rst_valid_o", valid_o, 2'b00);
    `CHK("async_rst_ready_o", ready_o, 1'b1);
    tick();
    `CHK("async_rst_next_valid_o", valid_o, 2'b00);

    drive(32'h100, 16'h0001, 16'h0093, 16'h0010, 16'h0085, 1'b0, 2'd0);
    #1 `CHK("mix_ready_o", ready_o, 1'b1);
    `CHK("mix_empty_valid_o", valid_o, 2'b00);
    tick(); idle();
    #1 `CHK("mix_c1_valid_o", valid_o, 2'b11);
    `CHK("mix_c1_s0_pc", instr_o[0].pc, 32'h100);
    `CHK("mix_c1_s0_comp", instr_o[0].is_compressed, 1'b1);
    `CHK("mix_c1_s1_pc", instr_o[1].pc, 32'h102);
    `CHK("mix_c1_s1_raw", instr_o[1].raw, 32'h00100093);
    `CHK("mix_c1_s1_comp", instr_o[1].is_compressed, 1'b0);
    tick();
    `CHK("mix_c2_valid_o", valid_o, 2'b01);
    `CHK("mix_c2_s0_pc", instr_o[0].pc, 32'h106);
    `CHK("mix_c2_s0_raw", instr_o[0].raw, 32'h00000085);
    tick();
    `CHK("mix_drained", valid_o, 2'b00);

    drive(32'h100, 16'h0001, 16'h0001, 16'h0001, 16'h0093, 1'b0, 2'd0);
    tick(); idle();
    #1 `CHK("split_c1_valid_o", valid_o, 2'b11);
    tick();
    drive(32'h108, 16'h0010, 16'h0085, 16'h0001, 16'h0001, 1'b0, 2'd0);
    #1 `CHK("split_wait_valid_o", valid_o, 2'b01);
    `CHK("split_wait_s0_pc", instr_o[0].pc, 32'h104);
    `CHK("split_wait_no_err", invalid_instruction, 1'b0);
    `CHK("split_ready_o", ready_o, 1'b1);
    tick(); idle();
    #1 `CHK("split_join_valid_o", valid_o, 2'b11);
    `CHK("split_join_s0_pc", instr_o[0].pc, 32'h106);
    `CHK("split_join_s0_raw", instr_o[0].raw, 32'h00100093);
    `CHK("split_join_s1_pc", instr_o[1].pc, 32'h10A);
    tick();
    `CHK("split_tail_s0_pc", instr_o[0].pc, 32'h10C);
    tick();
    `CHK("split_drained", valid_o, 2'b00);

    drive(32'h500, 16'h8082, 16'h0001, 16'h0001, 16'hA001, 1'b0, 2'd0);
    tick(); idle();
    #1 `CHK("ret_valid_o", valid_o, 2'b01);
    `CHK("ret_valid_branch", valid_branch, 2'b01);
    `CHK("ret_is_return", is_return_out, 1'b1);
    tick();
    `CHK("ret_next_valid_o", valid_o, 2'b11);
    `CHK("ret_next_is_return", is_return_out, 1'b0);
    tick();
    `CHK("cj_valid_o", valid_o, 2'b01);
    `CHK("cj_valid_branch", valid_branch, 2'b01);
    `CHK("cj_is_jumpl", is_jumpl_out, 1'b0);
    tick();
    `CHK("ret_drained", valid_o, 2'b00);

    drive(32'h600, 16'h0001, 16'hA001, 16'h0001, 16'h0001, 1'b1, 2'd1);
    tick(); idle();
    #1 `CHK("pred_ok_valid_o", valid_o, 2'b11);
    `CHK("pred_ok_valid_branch", valid_branch, 2'b10);
    `CHK("pred_ok_no_redirect", invalid_prediction, 1'b0);
    tick();
    `CHK("pred_ok_discarded", valid_o, 2'b00);

    drive(32'h100, 16'h0001, 16'h0001, 16'h0085, 16'h0001, 1'b1, 2'd2);
    tick(); idle();
    #1 `CHK("mispred_c1_valid_o", valid_o, 2'b11);
    `CHK("mispred_c1_flag", invalid_prediction, 1'b0);
    tick();
    `CHK("mispred_valid_o", valid_o, 2'b00);
    `CHK("mispred_flag", invalid_prediction, 1'b1);
    `CHK("mispred_old_pc", old_pc, 32'h104);
    tick();
    `CHK("mispred_pulse", invalid_prediction, 1'b0);
    `CHK("hold_old_pc", old_pc, 32'h104);
    drive(32'h200, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0, 2'd0);
    #1 `CHK("hold_ready_o", ready_o, 1'b1);
    tick(); idle();
    #1 `CHK("hold_dropped", valid_o, 2'b00);
    drive(32'h104, 16'h0085, 16'h0001, 16'h0001, 16'h0001, 1'b0, 2'd0);
    tick(); idle();
    #1 `CHK("restart_valid_o", valid_o, 2'b11);
    `CHK("restart_s0_pc", instr_o[0].pc, 32'h104);
    tick();
    `CHK("restart_c2_s0_pc", instr_o[0].pc, 32'h108);
    tick();
    `CHK("restart_drained", valid_o, 2'b00);

    drive(32'h108, 16'h0001, 16'h001F, 16'h0001, 16'h0001, 1'b0, 2'd0);
    tick(); idle();
    #1 `CHK("illegal_valid_o", valid_o, 2'b01);
    `CHK("illegal_s0_pc", instr_o[0].pc, 32'h108);
    `CHK("illegal_flag", invalid_instruction, 1'b1);
    `CHK("illegal_old_pc", old_pc, 32'h10A);
    tick();
    `CHK("illegal_pulse", invalid_instruction, 1'b0);
    `CHK("illegal_cleared", valid_o, 2'b00);

    flush_i = 1'b1;
    drive(32'h500, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0, 2'd0);
    tick();
    flush_i = 1'b0;
    drive(32'h300, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0, 2'd0);
    #1 `CHK("flush_ready_o", ready_o, 1'b1);
    tick(); idle();
    #1 `CHK("flush_valid_o", valid_o, 2'b11);
    `CHK("flush_s0_pc", instr_o[0].pc, 32'h300);
    tick(); tick();
    `CHK("flush_drained", valid_o, 2'b00);

    ready_i = 1'b0;
    drive(32'h400, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0, 2'd0);
    #1 `CHK("bp_p1_ready_o", ready_o, 1'b1);
    tick();
    drive(32'h408, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0, 2'd0);
    #1 `CHK("bp_p2_ready_o", ready_o, 1'b1);
    tick();
    drive(32'h410, 16'h0001, 16'h0001, 16'h0001, 16'h0001, 1'b0, 2'd0);
    #1 `CHK("bp_full_ready_o", ready_o, 1'b0);
    `CHK("bp_full_valid_o", valid_o, 2'b00);
    tick(); tick();
    `CHK("bp_still_full", ready_o, 1'b0);
    idle(); ready_i = 1'b1;
    #1 `CHK("bp_release_valid_o", valid_o, 2'b11);
    `CHK("bp_release_s0_pc", instr_o[0].pc, 32'h400);
    `CHK("bp_release_s1_pc", instr_o[1].pc, 32'h402);
    `CHK("bp_release_ready_o", ready_o, 1'b0);
    tick();
    `CHK("bp_c2_s0_pc", instr_o[0].pc, 32'h404);
    tick();
    `CHK("bp_c3_s0_pc", instr_o[0].pc, 32'h408);
    tick();
    `CHK("bp_c4_s1_pc", instr_o[1].pc, 32'h40E);
    tick();
    `CHK("bp_refused_packet", valid_o, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
